axis_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one AXI-stream sink (typically the slave port of the stream FIFO feeding the accelerator) between NUM_SRC AXI-stream producers. It grants one source at a time for bursts of up to BURST_LEN beats and forwards that source's data unchanged. The index of the granted source is reported alongside the data. Beat and grant status outputs feed the debug and status register bank.

---
 rtl/axis_rr_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_axis_rr_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter
// Round-robin arbiter sharing one AXI-stream sink between NUM_SRC producers.
// A granted source keeps the sink for up to BURST_LEN beats or until it goes
// idle, then drops to lowest priority. Data, valid and ready pass straight
// through while a grant is held; grant/status outputs come from registers.

`default_nettype none

module axis_rr_arbiter #(
    parameter int AXIS_BUS_WIDTH = 64,
    parameter int NUM_SRC        = 4,
    parameter int BURST_LEN      = 16
) (
    input  logic                                m_axi_aclk,
    input  logic                                m_axi_areset,
    input  logic [NUM_SRC*AXIS_BUS_WIDTH-1:0]   s_axis_tdata,
    input  logic [NUM_SRC-1:0]                  s_axis_tvalid,
    output logic [NUM_SRC-1:0]                  s_axis_tready,
    output logic [AXIS_BUS_WIDTH-1:0]           m_axis_tdata,
    output logic                                m_axis_tvalid,
    input  logic                                m_axis_tready,
    output logic [$clog2(NUM_SRC)-1:0]          m_axis_tid,
    output logic [NUM_SRC-1:0]                  o_grant,
    output logic                                o_busy,
    output logic [31:0]                         o_beat_count
);

    localparam int IDX_W = $clog2(NUM_SRC);
    localparam int CNT_W = $clog2(BURST_LEN + 1);

    // Value of burst_cnt when the beat that completes a burst is accepted.
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
    // Reset value of last_idx: makes source 0 the first to be scanned.
    localparam logic [IDX_W-1:0] LAST_SRC  = IDX_W'(NUM_SRC - 1);
    // NUM_SRC expressed in the width of the rotated-index adder.
    localparam logic [IDX_W:0]   SRC_COUNT = (IDX_W + 1)'(NUM_SRC);

    typedef enum logic {
        ARB,
        GRANT
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                 state_reg;
    logic [IDX_W-1:0]       grant_idx_reg;
    logic [IDX_W-1:0]       last_idx_reg;
    logic [CNT_W-1:0]       burst_cnt_reg;
    logic [31:0]            beat_count_reg;

    // Registered status outputs, valid only while a grant is held.
    logic [IDX_W-1:0]       tid_reg;
    logic [NUM_SRC-1:0]     grant_onehot_reg;
    logic                   busy_reg;

    // ------------------------------------------------------------------
    // Per-source data unpacking
    // ------------------------------------------------------------------
    logic [AXIS_BUS_WIDTH-1:0] src_data [NUM_SRC];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
            assign src_data[gi] = s_axis_tdata[gi*AXIS_BUS_WIDTH +: AXIS_BUS_WIDTH];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Rotated request scan
    // Candidate slot gi holds source (last_idx + 1 + gi) mod NUM_SRC, so
    // slot 0 is the highest-priority source for the next grant. The sum
    // never exceeds 2*NUM_SRC-1, so one conditional subtraction wraps it.
    // ------------------------------------------------------------------
    logic [IDX_W:0]         cand_sum   [NUM_SRC];
    logic [IDX_W-1:0]       cand_idx   [NUM_SRC];
    logic [NUM_SRC-1:0]     cand_valid;

    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_rotate
            assign cand_sum[gi]   = {1'b0, last_idx_reg} + (IDX_W + 1)'(gi + 1);
            assign cand_idx[gi]   = (cand_sum[gi] >= SRC_COUNT)
                                  ? IDX_W'(cand_sum[gi] - SRC_COUNT)
                                  : cand_sum[gi][IDX_W-1:0];
            assign cand_valid[gi] = s_axis_tvalid[cand_idx[gi]];
        end
    endgenerate

    logic                   pick_found;
    logic [IDX_W-1:0]       pick_idx;
    logic [NUM_SRC-1:0]     pick_onehot;

    // Lowest candidate slot with a valid request wins (scan from the far end
    // so the nearest slot overwrites).
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (cand_valid[k]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx[k];
            end
        end
    end

    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_pick_dec
            assign pick_onehot[gi] = (pick_idx == IDX_W'(gi));
        end
    endgenerate

    // ------------------------------------------------------------------
    // Grant-side handshake and release decision
    // ------------------------------------------------------------------
    logic                   in_grant;
    logic                   cur_valid;
    logic                   beat;
    logic                   burst_done;
    logic                   release_grant;

    assign in_grant      = (state_reg == GRANT);
    assign cur_valid     = s_axis_tvalid[grant_idx_reg];
    assign beat          = in_grant && cur_valid && m_axis_tready;
    assign burst_done    = beat && (burst_cnt_reg == LAST_BEAT);
    // An idle granted source gives up the sink at once; no beat is possible
    // in that cycle, so nothing is lost.
    assign release_grant = in_grant && (burst_done || !cur_valid);

    // ------------------------------------------------------------------
    // Zero-latency forwarding path
    // ------------------------------------------------------------------
    assign m_axis_tvalid = in_grant && cur_valid;
    assign m_axis_tdata  = in_grant ? src_data[grant_idx_reg] : '0;

    // grant_onehot_reg is all-zero in ARB, so no source sees ready there.
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_ready
            assign s_axis_tready[gi] = grant_onehot_reg[gi] & m_axis_tready;
        end
    endgenerate

    assign m_axis_tid   = tid_reg;
    assign o_grant      = grant_onehot_reg;
    assign o_busy       = busy_reg;
    assign o_beat_count = beat_count_reg;

    // ------------------------------------------------------------------
    // Arbitration FSM with registered status outputs and beat counters.
    // Reset wins over a beat in the same cycle, so such a beat is not counted.
    // ------------------------------------------------------------------
    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) begin
            state_reg        <= ARB;
            grant_idx_reg    <= '0;
            last_idx_reg     <= LAST_SRC;
            burst_cnt_reg    <= '0;
            beat_count_reg   <= '0;
            tid_reg          <= '0;
            grant_onehot_reg <= '0;
            busy_reg         <= 1'b0;
        end else begin
            case (state_reg)
                ARB: begin
                    if (pick_found) begin
                        state_reg        <= GRANT;
                        grant_idx_reg    <= pick_idx;
                        burst_cnt_reg    <= '0;
                        tid_reg          <= pick_idx;
                        grant_onehot_reg <= pick_onehot;
                        busy_reg         <= 1'b1;
                    end
                end
                GRANT: begin
                    if (beat) begin
                        burst_cnt_reg  <= burst_cnt_reg + CNT_W'(1);
                        beat_count_reg <= beat_count_reg + 32'd1;
                    end
                    if (release_grant) begin
                        state_reg        <= ARB;
                        last_idx_reg     <= grant_idx_reg;
                        tid_reg          <= '0;
                        grant_onehot_reg <= '0;
                        busy_reg         <= 1'b0;
                    end
                end
                default: begin
                    state_reg        <= ARB;
                    tid_reg          <= '0;
                    grant_onehot_reg <= '0;
                    busy_reg         <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_axis_rr_arbiter.sv
// Testbench for axis_rr_arbiter (NUM_SRC=4, BURST_LEN=4, 16-bit data).
// Table of per-cycle vectors for reset, fairness, early release and mid-burst
// reset, then hand-written sequences for backpressure and single requester.

module tb_axis_rr_arbiter;

    localparam int W = 16;
    localparam int N = 4;
    localparam int B = 4;

    logic             clk = 1'b0;
    logic             srst;
    logic [N*W-1:0]   s_tdata;
    logic [N-1:0]     s_tvalid;
    logic [N-1:0]     s_tready;
    logic [W-1:0]     m_tdata;
    logic             m_tvalid;
    logic             m_tready;
    logic [1:0]       m_tid;
    logic [N-1:0]     grant;
    logic             busy;
    logic [31:0]      beats;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    axis_rr_arbiter #(
        .AXIS_BUS_WIDTH (W),
        .NUM_SRC        (N),
        .BURST_LEN      (B)
    ) dut (
        .m_axi_aclk     (clk),
        .m_axi_areset   (srst),
        .s_axis_tdata   (s_tdata),
        .s_axis_tvalid  (s_tvalid),
        .s_axis_tready  (s_tready),
        .m_axis_tdata   (m_tdata),
        .m_axis_tvalid  (m_tvalid),
        .m_axis_tready  (m_tready),
        .m_axis_tid     (m_tid),
        .o_grant        (grant),
        .o_busy         (busy),
        .o_beat_count   (beats)
    );

    // Source model: each source presents {index, sequence}; the sequence
    // advances on every accepted handshake.
    logic [11:0] seq [N] = '{default: '0};

    always_comb begin
        for (int i = 0; i < N; i++) begin
            s_tdata[i*W +: W] = {4'(i), seq[i]};
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (s_tvalid[i] && s_tready[i]) seq[i] <= seq[i] + 12'd1;
        end
    end

    // Sink model: capture every word accepted at the sink.
    logic         rx_clr = 1'b0;
    logic [W-1:0] rx_buf [64];
    int           rx_n = 0;

    always @(posedge clk) begin
        if (rx_clr) begin
            rx_n <= 0;
        end else if (m_tvalid && m_tready && rx_n < 64) begin
            rx_buf[rx_n] <= m_tdata;
            rx_n         <= rx_n + 1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        srst;
        logic [3:0]  valid;
        logic        ready;
        logic        busy;
        logic [1:0]  tid;
        logic [31:0] beat;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic [3:0] v, input logic rd,
                                input logic b, input logic [1:0] t, input logic [31:0] bc);
        vec_t x;
        x.srst  = r;
        x.valid = v;
        x.ready = rd;
        x.busy  = b;
        x.tid   = t;
        x.beat  = bc;
        vecs.push_back(x);
    endfunction

    // Full output check for one cycle given the expected grant state.
    task automatic check_cycle(input int n, input logic b, input logic [1:0] t, input logic [31:0] bc);
        logic [3:0]  one;
        logic [3:0]  exp_ready;
        logic [3:0]  exp_grant;
        logic        exp_valid;
        logic [15:0] exp_data;
        one       = 4'b0001;
        exp_grant = b ? (one << t) : 4'b0000;
        exp_ready = (b && m_tready) ? (one << t) : 4'b0000;
        exp_valid = b && s_tvalid[t];
        exp_data  = b ? {4'(t), seq[t]} : 16'h0000;
        $display("vec %0d: srst=%0b valid=%b ready=%0b busy=%0b tid=%0d grant=%b beats=%0d",
                 n, srst, s_tvalid, m_tready, busy, m_tid, grant, beats);
        chk($sformatf("v%0d_busy", n),   64'(busy),     64'(b));
        chk($sformatf("v%0d_tid", n),    64'(m_tid),    64'(b ? t : 2'd0));
        chk($sformatf("v%0d_grant", n),  64'(grant),    64'(exp_grant));
        chk($sformatf("v%0d_sready", n), 64'(s_tready), 64'(exp_ready));
        chk($sformatf("v%0d_mvalid", n), 64'(m_tvalid), 64'(exp_valid));
        chk($sformatf("v%0d_mdata", n),  64'(m_tdata),  64'(exp_data));
        chk($sformatf("v%0d_beats", n),  64'(beats),    64'(bc));
    endtask

    logic [11:0] start;
    logic        exp_busy_sr [16];
    int          runs [4];
    int          ri;
    logic        prev_busy;

    initial begin
        srst     = 1'b1;
        s_tvalid = '0;
        m_tready = 1'b0;
        tick();

        // Reset held 3 cycles with every source valid: all outputs zero.
        for (int k = 0; k < 3; k++) add(1, 4'b1111, 1, 0, 0, 0);
        // Fairness: 0x4, bubble, 1x4, bubble, 2x4, bubble, 3x4, bubble.
        add(0, 4'b1111, 1, 0, 0, 0);
        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < 4; k++) add(0, 4'b1111, 1, 1, 2'(s), 32'(4*s + k));
            add(0, 4'b1111, 1, 0, 0, 32'(4*s + 4));
        end
        // Wraps back to source 0; reset asserted here, beat not counted.
        add(1, 4'b1100, 1, 1, 0, 16);
        // Early release: source 2 sends two beats then drops valid.
        add(0, 4'b1100, 1, 0, 0, 0);
        add(0, 4'b1100, 1, 1, 2, 0);
        add(0, 4'b1100, 1, 1, 2, 1);
        add(0, 4'b1000, 1, 1, 2, 2);
        add(0, 4'b1100, 1, 0, 0, 2);
        add(0, 4'b1100, 1, 1, 3, 2);
        add(0, 4'b1100, 1, 1, 3, 3);
        add(1, 4'b0000, 1, 1, 3, 4);
        // Mid-burst reset: source 1 reset after two beats, restart at 0.
        add(0, 4'b1111, 1, 0, 0, 0);
        for (int k = 0; k < 4; k++) add(0, 4'b1111, 1, 1, 0, 32'(k));
        add(0, 4'b1111, 1, 0, 0, 4);
        add(0, 4'b1111, 1, 1, 1, 4);
        add(0, 4'b1111, 1, 1, 1, 5);
        add(1, 4'b1111, 1, 1, 1, 6);
        add(0, 4'b1111, 1, 0, 0, 0);
        add(0, 4'b1111, 1, 1, 0, 0);

        foreach (vecs[n]) begin
            srst     = vecs[n].srst;
            s_tvalid = vecs[n].valid;
            m_tready = vecs[n].ready;
            @(negedge clk);
            check_cycle(n, vecs[n].busy, vecs[n].tid, vecs[n].beat);
            tick();
        end

        // Backpressure: only source 1 valid, sink ready 1,0,0,1,...
        srst     = 1'b1;
        s_tvalid = '0;
        m_tready = 1'b0;
        rx_clr   = 1'b1;
        tick();
        tick();
        srst     = 1'b0;
        rx_clr   = 1'b0;
        start    = seq[1];
        s_tvalid = 4'b0010;
        @(negedge clk);
        chk("bp_arb_busy", 64'(busy), 64'(0));
        tick();
        for (int p = 0; p < 10; p++) begin
            m_tready = (p % 3 == 0);
            @(negedge clk);
            $display("bp cycle %0d: ready=%0b busy=%0b tid=%0d beats=%0d", p, m_tready, busy, m_tid, beats);
            chk($sformatf("bp%0d_busy", p),   64'(busy),     64'(1));
            chk($sformatf("bp%0d_tid", p),    64'(m_tid),    64'(1));
            chk($sformatf("bp%0d_mvalid", p), 64'(m_tvalid), 64'(1));
            chk($sformatf("bp%0d_beats", p),  64'(beats),    64'(p / 3 + ((p % 3 == 0) ? 0 : 1)));
            tick();
        end
        m_tready = 1'b1;
        @(negedge clk);
        chk("bp_release_busy", 64'(busy), 64'(0));
        chk("bp_beats", 64'(beats), 64'(4));
        chk("bp_rx_count", 64'(rx_n), 64'(4));
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("bp_rx%0d", k), 64'(rx_buf[k]), 64'({4'd1, 12'(start + 12'(k))}));
        end

        // Single requester: source 1 streams 10 words, bursts 4, 4, 2.
        srst     = 1'b1;
        s_tvalid = '0;
        rx_clr   = 1'b1;
        tick();
        tick();
        srst   = 1'b0;
        rx_clr = 1'b0;
        start  = seq[1];
        exp_busy_sr = '{0,1,1,1,1,0,1,1,1,1,0,1,1,1,0,0};
        runs      = '{default: 0};
        ri        = 0;
        prev_busy = 1'b0;
        m_tready  = 1'b1;
        for (int c = 0; c < 16; c++) begin
            s_tvalid = (12'(seq[1] - start) < 12'd10) ? 4'b0010 : 4'b0000;
            @(negedge clk);
            $display("sr cycle %0d: valid=%b busy=%0b tid=%0d beats=%0d", c, s_tvalid, busy, m_tid, beats);
            chk($sformatf("sr%0d_busy", c), 64'(busy), 64'(exp_busy_sr[c]));
            if (exp_busy_sr[c]) chk($sformatf("sr%0d_tid", c), 64'(m_tid), 64'(1));
            if (!busy && prev_busy && ri < 3) ri++;
            if (busy && m_tvalid && m_tready) runs[ri]++;
            prev_busy = busy;
            tick();
        end
        @(negedge clk);
        chk("sr_run0", 64'(runs[0]), 64'(4));
        chk("sr_run1", 64'(runs[1]), 64'(4));
        chk("sr_run2", 64'(runs[2]), 64'(2));
        chk("sr_beats", 64'(beats), 64'(10));
        chk("sr_rx_count", 64'(rx_n), 64'(10));
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("sr_rx%0d", k), 64'(rx_buf[k]), 64'({4'd1, 12'(start + 12'(k))}));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
